// File: rtl/i2c_slave.sv
// Oversampled I2C target: fixed 7-bit address, write bytes to dout, read bytes from din, no clock stretching.
// Define I2C_SLAVE_FILTER_EN to add a FILTER_LEN-sample stability filter on the synchronized SCL/SDA lines.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1000110,
  parameter int         FILTER_LEN = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       SCL,
  inout  wire        SDA,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       wr_valid,
  output logic       rd_req,
  output logic       busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  if (FILTER_LEN < 2 || FILTER_LEN > 15) begin : g_filter_len_check
    $error("i2c_slave: FILTER_LEN must be within 2..15");
  end

  logic [1:0] scl_sync_r, sda_sync_r;
  logic       scl_line_s, sda_line_s;
  logic       scl_prev_r, sda_prev_r;
  logic       scl_rise_r, scl_fall_r, start_r, stop_r;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic       rw_r;
  logic       sda_low_r;

  // Two-flop synchronizers; the bus idles high so reset to 1.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
    end else begin
      scl_sync_r <= {scl_sync_r[0], SCL};
      sda_sync_r <= {sda_sync_r[0], SDA};
    end
  end

`ifdef I2C_SLAVE_FILTER_EN
  localparam logic [3:0] FILT_LAST = 4'(FILTER_LEN - 1);
  logic       scl_filt_r, sda_filt_r;
  logic [3:0] scl_cnt_r, sda_cnt_r;

  // A line follows its input only after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_filt_r <= 1'b1;
      sda_filt_r <= 1'b1;
      scl_cnt_r  <= 4'd0;
      sda_cnt_r  <= 4'd0;
    end else begin
      if (scl_sync_r[1] == scl_filt_r) begin
        scl_cnt_r <= 4'd0;
      end else if (scl_cnt_r == FILT_LAST) begin
        scl_filt_r <= scl_sync_r[1];
        scl_cnt_r  <= 4'd0;
      end else begin
        scl_cnt_r <= scl_cnt_r + 4'd1;
      end
      if (sda_sync_r[1] == sda_filt_r) begin
        sda_cnt_r <= 4'd0;
      end else if (sda_cnt_r == FILT_LAST) begin
        sda_filt_r <= sda_sync_r[1];
        sda_cnt_r  <= 4'd0;
      end else begin
        sda_cnt_r <= sda_cnt_r + 4'd1;
      end
    end
  end

  assign scl_line_s = scl_filt_r;
  assign sda_line_s = sda_filt_r;
`else
  assign scl_line_s = scl_sync_r[1];
  assign sda_line_s = sda_sync_r[1];
`endif

  // Registered bus events; sda_prev_r is the SDA value aligned with each event.
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
      scl_rise_r <= 1'b0;
      scl_fall_r <= 1'b0;
      start_r    <= 1'b0;
      stop_r     <= 1'b0;
    end else begin
      scl_prev_r <= scl_line_s;
      sda_prev_r <= sda_line_s;
      scl_rise_r <= scl_line_s & ~scl_prev_r;
      scl_fall_r <= ~scl_line_s & scl_prev_r;
      start_r    <= scl_line_s & scl_prev_r & sda_prev_r & ~sda_line_s;
      stop_r     <= scl_line_s & scl_prev_r & ~sda_prev_r & sda_line_s;
    end
  end

  // Protocol state machine; START/STOP override any SCL edge in the same clock.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'h00;
      rw_r      <= 1'b0;
      sda_low_r <= 1'b0;
      dout      <= 8'h00;
      wr_valid  <= 1'b0;
      rd_req    <= 1'b0;
      busy      <= 1'b0;
    end else begin
      wr_valid <= 1'b0;
      rd_req   <= 1'b0;
      if (start_r) begin
        state_r   <= ADDR;
        bit_cnt_r <= 4'd0;
        sda_low_r <= 1'b0;
        busy      <= 1'b0;
      end else if (stop_r) begin
        state_r   <= IDLE;
        bit_cnt_r <= 4'd0;
        sda_low_r <= 1'b0;
        busy      <= 1'b0;
      end else begin
        case (state_r)
          IDLE: begin
            sda_low_r <= 1'b0;
          end
          ADDR: begin
            if (scl_rise_r) begin
              shift_r   <= {shift_r[6:0], sda_prev_r};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_r && bit_cnt_r == 4'd8) begin
              rw_r <= shift_r[0];
              if (shift_r[7:1] == SLAVE_ADDR) begin
                sda_low_r <= 1'b1;
                busy      <= 1'b1;
                state_r   <= ADDR_ACK;
              end else begin
                state_r <= WAIT_STOP;
              end
            end else begin
              sda_low_r <= 1'b0;
            end
          end
          ADDR_ACK: begin
            if (scl_fall_r) begin
              if (rw_r) begin
                shift_r   <= din;
                rd_req    <= 1'b1;
                sda_low_r <= ~din[7];
                bit_cnt_r <= 4'd1;
                state_r   <= RD_DATA;
              end else begin
                sda_low_r <= 1'b0;
                bit_cnt_r <= 4'd0;
                state_r   <= WR_DATA;
              end
            end else begin
              sda_low_r <= 1'b1;
            end
          end
          WR_DATA: begin
            if (scl_rise_r) begin
              shift_r   <= {shift_r[6:0], sda_prev_r};
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if (bit_cnt_r == 4'd7) begin
                dout     <= {shift_r[6:0], sda_prev_r};
                wr_valid <= 1'b1;
              end
            end else if (scl_fall_r && bit_cnt_r == 4'd8) begin
              sda_low_r <= 1'b1;
              state_r   <= WR_ACK;
            end else begin
              sda_low_r <= 1'b0;
            end
          end
          WR_ACK: begin
            if (scl_fall_r) begin
              sda_low_r <= 1'b0;
              bit_cnt_r <= 4'd0;
              state_r   <= WR_DATA;
            end else begin
              sda_low_r <= 1'b1;
            end
          end
          RD_DATA: begin
            if (scl_fall_r) begin
              if (bit_cnt_r == 4'd8) begin
                sda_low_r <= 1'b0;
                state_r   <= RD_ACK;
              end else begin
                sda_low_r <= ~shift_r[6];
                shift_r   <= {shift_r[6:0], 1'b0};
                bit_cnt_r <= bit_cnt_r + 4'd1;
              end
            end else begin
              sda_low_r <= sda_low_r;
            end
          end
          RD_ACK: begin
            // bit_cnt_r == 9 records that the master ACKed this byte.
            if (scl_rise_r) begin
              if (sda_prev_r) begin
                state_r <= WAIT_STOP;
              end else begin
                bit_cnt_r <= 4'd9;
              end
            end else if (scl_fall_r && bit_cnt_r == 4'd9) begin
              shift_r   <= din;
              rd_req    <= 1'b1;
              sda_low_r <= ~din[7];
              bit_cnt_r <= 4'd1;
              state_r   <= RD_DATA;
            end else begin
              sda_low_r <= 1'b0;
            end
          end
          WAIT_STOP: begin
            sda_low_r <= 1'b0;
          end
          default: begin
            state_r   <= IDLE;
            sda_low_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SDA = sda_low_r ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-level I2C master task set, a transaction-level model and a per-cycle compare process.
module tb_i2c_slave;
  localparam logic [6:0] ADDR = 7'h46;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       scl = 1'b1;
  logic       master_low = 1'b0;
  logic [7:0] din = 8'h00;
  wire  [7:0] dout;
  wire        wr_valid, rd_req, busy;
  wire        sda_bus;
  logic       sda_val;

  pullup (sda_bus);
  assign sda_bus = master_low ? 1'b0 : 1'bz;
  assign sda_val = (sda_bus === 1'b0) ? 1'b0 : 1'b1;

  i2c_slave #(.SLAVE_ADDR(ADDR), .FILTER_LEN(3)) dut (
    .clk(clk), .reset(reset), .SCL(scl), .SDA(sda_bus), .din(din),
    .dout(dout), .wr_valid(wr_valid), .rd_req(rd_req), .busy(busy)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic       slave_may_drive = 1'b0;
  logic       prev_owned = 1'b0;
  logic [7:0] exp_wr_q[$];
  logic [7:0] model_dout = 8'h00;
  int         rd_seen = 0;
  int         exp_rd = 0;
  logic       wr_prev = 1'b0;
  logic       rd_prev = 1'b0;
`ifdef I2C_SLAVE_FILTER_EN
  logic       glitch_arm = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle checks: drive window, pulse shape, write scoreboard, read-request count.
  always @(posedge clk) begin
    #2;
    if (!reset) begin
      chk("pulse_overlap", {31'd0, wr_valid & rd_req}, 32'd0);
      if (!master_low && !slave_may_drive) chk("sda_released", {31'd0, sda_val}, 32'd1);
      if (wr_valid) begin
        chk("wr_valid_width", {31'd0, wr_prev}, 32'd0);
        chk("wr_valid_expected", {31'd0, exp_wr_q.size() != 0}, 32'd1);
        if (exp_wr_q.size() != 0) model_dout = exp_wr_q.pop_front();
        chk("dout_update", {24'd0, dout}, {24'd0, model_dout});
      end else begin
        chk("dout_hold", {24'd0, dout}, {24'd0, model_dout});
      end
      if (rd_req) begin
        rd_seen++;
        chk("rd_req_width", {31'd0, rd_prev}, 32'd0);
      end
    end
    wr_prev = wr_valid;
    rd_prev = rd_req;
  end

  // One SCL period: SDA set mid-low, sampled at the end of the high phase.
  task automatic bit_xfer(input logic mbit, input logic slave_owns, output logic sampled);
    slave_may_drive = prev_owned | slave_owns;
    repeat (10) @(negedge clk);
    slave_may_drive = slave_owns;
    master_low = slave_owns ? 1'b0 : ~mbit;
    repeat (2) @(negedge clk);
`ifdef I2C_SLAVE_FILTER_EN
    if (glitch_arm) begin
      scl = 1'b1;
      repeat (2) @(negedge clk);
      scl = 1'b0;
      repeat (10) @(negedge clk);
    end
`endif
    scl = 1'b1;
    repeat (10) @(negedge clk);
    sampled = sda_val;
    scl = 1'b0;
    prev_owned = slave_owns;
  endtask

  task automatic start_cond();
    if (scl == 1'b0) begin
      slave_may_drive = prev_owned;
      repeat (10) @(negedge clk);
      slave_may_drive = 1'b0;
      master_low = 1'b0;
      repeat (2) @(negedge clk);
      scl = 1'b1;
      repeat (10) @(negedge clk);
    end
    master_low = 1'b1;
    repeat (10) @(negedge clk);
    chk("busy_after_start", {31'd0, busy}, 32'd0);
    scl = 1'b0;
    prev_owned = 1'b0;
  endtask

  task automatic stop_cond();
    slave_may_drive = prev_owned;
    repeat (10) @(negedge clk);
    slave_may_drive = 1'b0;
    master_low = 1'b1;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    repeat (10) @(negedge clk);
    master_low = 1'b0;
    repeat (10) @(negedge clk);
    chk("busy_after_stop", {31'd0, busy}, 32'd0);
    prev_owned = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, s);
    bit_xfer(1'b1, 1'b1, ack);
  endtask

  task automatic read_byte(input logic [7:0] next_din, input logic master_ack, output logic [7:0] b);
    logic s;
    b = 8'h00;
    for (int i = 0; i < 8; i++) begin
      bit_xfer(1'b1, 1'b1, s);
      b = {b[6:0], s};
      if (i == 0) din = next_din;
    end
    bit_xfer(~master_ack, 1'b0, s);
  endtask

  // Transaction model: ACK iff the address matches; written bytes reach dout in order; read bytes equal din.
  task automatic xfer(input logic [6:0] addr, input logic rw, input logic [7:0] data [4],
                      input int n, input logic end_stop);
    logic       ack, match;
    logic [7:0] b, nxt;
    match = (addr == ADDR);
    din = data[0];
    start_cond();
    send_byte({addr, rw}, ack);
    chk("addr_ack", {31'd0, ack}, {31'd0, !match});
    chk("busy_addressed", {31'd0, busy}, {31'd0, match});
    if (match) begin
      for (int k = 0; k < n; k++) begin
        if (!rw) begin
          exp_wr_q.push_back(data[k]);
          send_byte(data[k], ack);
          chk("data_ack", {31'd0, ack}, 32'd0);
        end else begin
          nxt = (k + 1 < n) ? data[k + 1] : 8'($urandom);
          read_byte(nxt, k + 1 < n, b);
          chk("read_byte", {24'd0, b}, {24'd0, data[k]});
          exp_rd++;
        end
      end
    end
    if (end_stop) begin
      stop_cond();
      chk("wr_drained", exp_wr_q.size(), 32'd0);
      chk("rd_req_count", rd_seen, exp_rd);
    end
  endtask

  task automatic reset_mid_byte();
    logic       ack, s;
    logic [7:0] b;
    b = 8'h6E;
    start_cond();
    send_byte({ADDR, 1'b0}, ack);
    chk("rst_addr_ack", {31'd0, ack}, 32'd0);
    exp_wr_q.push_back(b);
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], 1'b0, s);
    slave_may_drive = 1'b1;
    repeat (10) @(negedge clk);
    master_low = 1'b0;
    repeat (2) @(negedge clk);
    scl = 1'b1;
    repeat (5) @(negedge clk);
    chk("ack_before_reset", {31'd0, sda_val}, 32'd0);
    reset = 1'b1;
    model_dout = 8'h00;
    slave_may_drive = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_sda_released", {31'd0, sda_val}, 32'd1);
    chk("rst_dout", {24'd0, dout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("rst_rd_req", {31'd0, rd_req}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    scl = 1'b0;
    prev_owned = 1'b0;
    for (int i = 0; i < 9; i++) bit_xfer(i[0], 1'b0, s);
    stop_cond();
  endtask

  initial begin
    logic [7:0] d [4];
    logic [6:0] a;
    logic       rw, es;
    int         n;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("reset_dout", {24'd0, dout}, 32'd0);
    chk("reset_wr_valid", {31'd0, wr_valid}, 32'd0);
    chk("reset_rd_req", {31'd0, rd_req}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_sda", {31'd0, sda_val}, 32'd1);

    d = '{8'hB5, 8'h00, 8'h00, 8'h00};
    xfer(7'h46, 1'b0, d, 1, 1'b1);
    chk("dout_b5", {24'd0, dout}, 32'h0000_00B5);
    d = '{8'h5A, 8'h00, 8'h00, 8'h00};
    xfer(7'h47, 1'b0, d, 1, 1'b1);
    xfer(7'h00, 1'b0, d, 1, 1'b1);
    chk("dout_after_mismatch", {24'd0, dout}, 32'h0000_00B5);
    d = '{8'hA5, 8'h00, 8'h00, 8'h00};
    xfer(7'h46, 1'b1, d, 1, 1'b1);
    chk("rd_req_after_a5", rd_seen, 32'd1);
    d = '{8'h3C, 8'hC3, 8'h00, 8'h00};
    xfer(7'h46, 1'b1, d, 2, 1'b1);
    chk("rd_req_after_3c_c3", rd_seen, 32'd3);
    d = '{8'h11, 8'h22, 8'h00, 8'h00};
    xfer(7'h46, 1'b0, d, 1, 1'b0);
    d = '{8'h96, 8'h69, 8'h00, 8'h00};
    xfer(7'h46, 1'b1, d, 2, 1'b1);
    reset_mid_byte();
`ifdef I2C_SLAVE_FILTER_EN
    glitch_arm = 1'b1;
    d = '{8'hD2, 8'h4B, 8'h00, 8'h00};
    xfer(7'h46, 1'b0, d, 2, 1'b1);
    chk("glitch_dout", {24'd0, dout}, 32'h0000_004B);
    glitch_arm = 1'b0;
`endif

    for (int t = 0; t < 25; t++) begin
      a = 7'($urandom_range(0, 127));
      if ($urandom_range(0, 1) == 0) a = ADDR;
      else if (a == ADDR) a = a ^ 7'h01;
      rw = 1'($urandom_range(0, 1));
      n  = $urandom_range(1, 3);
      for (int j = 0; j < 4; j++) d[j] = 8'($urandom);
      es = (t == 24) ? 1'b1 : 1'($urandom_range(0, 1));
      xfer(a, rw, d, n, es);
    end

    repeat (10) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/i2c_slave.md
# i2c_slave

Oversampled I2C target (slave) that answers the existing `i2c_master` on the same SDA/SCL open-drain bus. SCL and SDA are sampled on the system clock, and the block detects START/STOP and matches a fixed 7-bit address. It ACKs write bytes and presents them on `dout`, and shifts `din` out for reads. No clock stretching: the master owns SCL, and the slave only ever pulls SDA low.

## Interface
- `SLAVE_ADDR`, default 7'b1000110: 7-bit address this target responds to.
- `FILTER_LEN`, default 3: stability count for the optional input filter (2..15).
- `clk`  input  1  system clock; every register is on its rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `SCL`  input  1  bus clock from the master; pulled up externally.
- `SDA`  inout  1  open-drain data; driven `1'b0` or `1'bz` only, never `1'b1`.
- `din`  input  8  read data; latched when `rd_req` pulses.
- `dout`  output  8  last byte written by the master.
- `wr_valid`  output  1  one-clk pulse when `dout` is updated.
- `rd_req`  output  1  one-clk pulse when `din` is captured for transmit.
- `busy`  output  1  high while this target is addressed (ADDR_ACK through the end of the transfer).

## Operation
- Input path:
  - 2-FF synchronizer on both SCL and SDA, then an edge detector on the synchronized values.
  - Events: `scl_rise`, `scl_fall`, `start` (SDA falls while SCL is high), `stop` (SDA rises while SCL is high).
- State machine: IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP.
- START from any state, including a repeated start:
  - go to ADDR, clear the bit counter, release SDA;
  - drop `busy` until the next address match.
- STOP from any state: go to IDLE, release SDA, `busy`=0.
- ADDR:
  - sample SDA on 8 `scl_rise` events, MSB first: 7 address bits, then R/W (1 = read).
  - On the 8th `scl_fall`: if the address matches, drive SDA low and enter ADDR_ACK; otherwise enter WAIT_STOP with SDA released.
- ADDR_ACK: at the next `scl_fall` (end of the ACK bit):
  - R/W=0: release SDA and enter WR_DATA.
  - R/W=1: load `din` into the shift register, pulse `rd_req`, drive the MSB (low if 0, released if 1) and enter RD_DATA.
- WR_DATA:
  - shift 8 bits on `scl_rise`.
  - On the 8th bit: in the same clock, `dout` takes the new byte and `wr_valid` pulses.
  - At the following `scl_fall`: drive the ACK low and enter WR_ACK.
- WR_ACK: at the next `scl_fall`, release SDA and return to WR_DATA. Any number of bytes is allowed per transfer.
- RD_DATA:
  - present the next bit on each `scl_fall`.
  - After the 8th bit's `scl_fall`: release SDA and enter RD_ACK.
- RD_ACK: sample SDA on `scl_rise`.
  - 0 (master ACK): at the next `scl_fall`, reload `din`, pulse `rd_req`, drive the MSB, return to RD_DATA.
  - 1 (NACK): enter WAIT_STOP with SDA released.
- WAIT_STOP: ignore SCL and keep SDA released until a START or STOP.
- Not supported: general call (0x00) and 10-bit addressing; both are treated as a mismatch.

## Timing
- Reset values:
  - `dout`=8'h00, `wr_valid`=0, `rd_req`=0, `busy`=0;
  - SDA released; state IDLE; counters cleared.
- Reset mid-transfer: the target immediately releases SDA and ignores the bus until the next START.
- Bus-event latency: an SDA or SCL pin change becomes an internal event 3 clk later (2 synchronizer flops + edge register), plus `FILTER_LEN` clk when the filter is enabled.
- Drive latency: SDA is updated 1 clk after `scl_fall` is detected, i.e. well inside the SCL low phase.
- Minimum SCL high and low phase: 4 clk without the filter, `FILTER_LEN`+4 clk with it. Shorter phases are out of contract.
- Simultaneous events: `start`/`stop` take priority over any `scl_rise`/`scl_fall` in the same clk.
- The master must change SDA only while SCL is low, except for START and STOP.
- `wr_valid` and `rd_req` are single-clk pulses; they never overlap and are never back-to-back within one byte.

## Configuration
- `I2C_SLAVE_FILTER_EN` defined:
  - each synchronized line passes through a stability filter;
  - the filtered value changes only after `FILTER_LEN` consecutive equal samples;
  - pulses shorter than `FILTER_LEN` clk are rejected.
- Undefined: the synchronized lines feed the edge detector directly, and `FILTER_LEN` is unused.

## Test plan
- Write to address 0x46, data 8'hB5, then STOP:
  - SDA pulled low during the 9th SCL of the address phase and of the data phase;
  - `dout`=8'hB5 with exactly one `wr_valid` pulse; `busy` returns to 0 after STOP.
- Write to address 0x47 (mismatch): SDA never driven low, no `wr_valid`, `busy` stays 0.
- Read from 0x46 with `din`=8'hA5 and a master NACK:
  - SDA bit sequence 1,0,1,0,0,1,0,1;
  - one `rd_req`; the target releases SDA and waits for STOP.
- Two-byte read, `din`=8'h3C then 8'hC3, master ACK then NACK: both bytes appear on SDA and `rd_req` pulses twice.
- Repeated START after a write byte, followed by a read: state returns to ADDR, and the read proceeds with ACK. Separately, assert `reset` mid-byte: SDA is released within 1 clk and all outputs return to reset values.
- With `I2C_SLAVE_FILTER_EN` and `FILTER_LEN`=3: a 2-clk glitch on SCL is ignored, and received data is unchanged.
